// File: rtl/regfile_writeback.sv
// Write-side controller for the BRISC register file: merges ALU results and
// FIFO-buffered load results onto one write port and tracks outstanding loads.
module regfile_writeback #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alu_valid,
  input  logic [ADDR_WIDTH-1:0]         alu_addr,
  input  logic [DATA_WIDTH-1:0]         alu_data,
  input  logic                          issue_valid,
  input  logic [ADDR_WIDTH-1:0]         issue_addr,
  input  logic                          mem_valid,
  input  logic [ADDR_WIDTH-1:0]         mem_addr,
  input  logic [DATA_WIDTH-1:0]         mem_data,
  output logic                          mem_ready,
  output logic                          write_enable,
  output logic [ADDR_WIDTH-1:0]         write_addr,
  output logic [DATA_WIDTH-1:0]         write_data,
  output logic                          write_src,
  output logic [(2**ADDR_WIDTH)-1:0]    pending,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          order_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t                  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  entry_t                  head;
  logic                    push;
  logic                    pop;
  logic                    clear_hit;
  logic                    err_now;
  logic [(2**ADDR_WIDTH)-1:0] pending_next;

  assign mem_ready = (fifo_count < DEPTH_C);
  assign push      = mem_valid & mem_ready;
  // The ALU always owns the port when it has a result; loads only drain in idle slots.
  assign pop       = ~alu_valid & (fifo_count != '0);
  assign head      = fifo_mem[rd_ptr];
  assign clear_hit = pop & (head.addr == issue_addr);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    pending_next = pending;
    if (pop)         pending_next[head.addr]  = 1'b0;
    if (issue_valid) pending_next[issue_addr] = 1'b1;
  end

  always_comb begin
    err_now = 1'b0;
    if (alu_valid && pending[alu_addr])                     err_now = 1'b1;
    if (issue_valid && pending[issue_addr] && !clear_hit)   err_now = 1'b1;
    if (push && !pending[mem_addr])                         err_now = 1'b1;
  end

  // NOTE: storage array is deliberately not reset; the count and pointers
  // alone decide which entries are valid, so stale contents are never read.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {mem_addr, mem_data};
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      pending    <= '0;
      order_err  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      pending <= pending_next;
      if (err_now) order_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
      write_src    <= 1'b0;
    end else if (alu_valid) begin
      write_enable <= 1'b1;
      write_addr   <= alu_addr;
      write_data   <= alu_data;
      write_src    <= 1'b0;
    end else if (pop) begin
      write_enable <= 1'b1;
      write_addr   <= head.addr;
      write_data   <= head.data;
      write_src    <= 1'b1;
    end else begin
      write_enable <= 1'b0;
    end
  end

endmodule
